// File: rtl/alu_seq_pkg.sv
// Shared types and instruction-word field layout for the ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // Word layout from LSB upward: op, a, b, acc.
    function automatic int instr_w(input int data_w, input int op_w);
        return 1 + 2 * data_w + op_w;
    endfunction

    function automatic int a_lsb(input int op_w);
        return op_w;
    endfunction

    function automatic int b_lsb(input int data_w, input int op_w);
        return op_w + data_w;
    endfunction

    function automatic int acc_pos(input int data_w, input int op_w);
        return op_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port.
module seq_prog_mem #(
    parameter int DEPTH = 32,
    parameter int IW    = 17,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Steps through a small program, issuing one operation at a time to an
// external ALU and waiting (with timeout) for its completion handshake.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  OP_W    = 4,
    parameter int  DEPTH   = 32,
    parameter int  TIMEOUT = 255,
    localparam int AW      = $clog2(DEPTH),
    localparam int IW      = instr_w(DATA_W, OP_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [IW-1:0]     prog_wdata,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [AW-1:0]     last_addr,
    input  logic              alu_done,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   op,
    output logic              acc,
    output logic              alu_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     pc,
    output logic [15:0]       op_count
);

    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam int          A_LSB   = a_lsb(OP_W);
    localparam int          B_LSB   = b_lsb(DATA_W, OP_W);
    localparam int          ACC_POS = acc_pos(DATA_W, OP_W);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    seq_state_t    state, state_d;
    logic [AW-1:0] pc_d;
    logic [15:0]   op_count_d;
    logic [TW-1:0] timer, timer_d;
    logic          stop_req, stop_req_d;
    logic          err_d, done_d, alu_en_d;
    logic          load_word;
    logic          mem_we;
    logic [IW-1:0] word;

    // The program may only change while nothing is executing from it.
    assign mem_we = prog_we && (state == IDLE);
    assign busy   = (state != IDLE);

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (word)
    );

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        op_count_d = op_count;
        timer_d    = timer;
        stop_req_d = stop_req;
        err_d      = err;
        done_d     = 1'b0;
        alu_en_d   = 1'b0;
        load_word  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d    = ISSUE;
                    pc_d       = '0;
                    op_count_d = '0;
                    err_d      = 1'b0;
                    stop_req_d = 1'b0;
                end
            end
            ISSUE: begin
                load_word = 1'b1;
                alu_en_d  = 1'b1;
                timer_d   = '0;
                state_d   = WAIT;
                if (stop) stop_req_d = 1'b1;
            end
            WAIT: begin
                if (stop) stop_req_d = 1'b1;
                // A completion arriving on the timeout cycle still counts.
                if (alu_done) begin
                    if (op_count != CNT_MAX) op_count_d = op_count + 16'd1;
                    if (stop_req || stop) begin
                        state_d = IDLE;
                    end else if (pc == last_addr) begin
                        if (loop_en) begin
                            pc_d    = '0;
                            state_d = ISSUE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        pc_d    = pc + AW'(1);
                        state_d = ISSUE;
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            op_count <= '0;
            timer    <= '0;
            stop_req <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
            alu_en   <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            op_count <= op_count_d;
            timer    <= timer_d;
            stop_req <= stop_req_d;
            err      <= err_d;
            done     <= done_d;
            alu_en   <= alu_en_d;
        end
    end

    // Operand registers hold the last issued word until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a   <= '0;
            b   <= '0;
            op  <= '0;
            acc <= 1'b0;
        end else if (load_word) begin
            a   <= word[A_LSB +: DATA_W];
            b   <= word[B_LSB +: DATA_W];
            op  <= word[OP_W-1:0];
            acc <= word[ACC_POS];
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: cycle-by-cycle comparison against a
// behavioural program-execution model, plus hand-computed run checks.
module tb_alu_sequencer;

    localparam int DW = 8, OW = 4, DEP = 8, TO = 4, AW = 3, IW = 21;
    localparam int IW16 = 38;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_wdata = '0;
    logic          start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          alu_done;
    logic          resp_done = 1'b0, man_done = 1'b0, resp_on = 1'b0;
    logic [DW-1:0] a, b;
    logic [OW-1:0] op;
    logic          acc, alu_en, busy, done, err;
    logic [AW-1:0] pc;
    logic [15:0]   op_count;

    logic            p16_we = 1'b0, start16 = 1'b0;
    logic [1:0]      p16_addr = '0, last16 = '0;
    logic [IW16-1:0] p16_wdata = '0;
    logic [15:0]     a16, b16, cnt16;
    logic [4:0]      op16;
    logic            acc16, alu_en16, busy16, done16, err16;
    logic [1:0]      pc16;

    assign alu_done = resp_done | man_done;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(DW), .OP_W(OW), .DEPTH(DEP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .stop(stop), .loop_en(loop_en),
        .last_addr(last_addr), .alu_done(alu_done), .a(a), .b(b), .op(op),
        .acc(acc), .alu_en(alu_en), .busy(busy), .done(done), .err(err),
        .pc(pc), .op_count(op_count)
    );

    alu_sequencer #(.DATA_W(16), .OP_W(5), .DEPTH(4), .TIMEOUT(8)) dut16 (
        .clk(clk), .rst(rst), .prog_we(p16_we), .prog_addr(p16_addr),
        .prog_wdata(p16_wdata), .start(start16), .stop(1'b0), .loop_en(1'b0),
        .last_addr(last16), .alu_done(1'b0), .a(a16), .b(b16), .op(op16),
        .acc(acc16), .alu_en(alu_en16), .busy(busy16), .done(done16), .err(err16),
        .pc(pc16), .op_count(cnt16)
    );

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mkw(input int acc_v, input int b_v, input int a_v, input int op_v);
        return IW'((acc_v << 20) + (b_v << 12) + (a_v << 4) + op_v);
    endfunction

    // Behavioural model: a program runs op by op; each op is issued on the
    // edge after it becomes current, then waits for alu_done or TO cycles.
    logic [IW-1:0] model_mem [DEP];
    logic          m_running = 0, m_issue_next = 0, m_stop = 0;
    logic          m_alu_en = 0, m_done = 0, m_err = 0, m_acc = 0;
    logic [DW-1:0] m_a = 0, m_b = 0;
    logic [OW-1:0] m_op = 0;
    int            m_pc = 0, m_cnt = 0, m_waited = 0;
    int            cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_running = 0; m_issue_next = 0; m_stop = 0; m_alu_en = 0; m_done = 0;
            m_err = 0; m_a = 0; m_b = 0; m_op = 0; m_acc = 0; m_pc = 0; m_cnt = 0; m_waited = 0;
        end else begin
            m_done = 0;
            m_alu_en = 0;
            if (!m_running) begin
                if (prog_we) model_mem[prog_addr] = prog_wdata;
                if (start) begin
                    m_running = 1; m_issue_next = 1; m_pc = 0; m_cnt = 0; m_err = 0; m_stop = 0;
                end
            end else if (m_issue_next) begin
                m_op  = OW'(model_mem[m_pc]);
                m_a   = DW'(model_mem[m_pc] >> 4);
                m_b   = DW'(model_mem[m_pc] >> 12);
                m_acc = 1'(model_mem[m_pc] >> 20);
                m_alu_en = 1; m_waited = 0; m_issue_next = 0;
                if (stop) m_stop = 1;
            end else begin
                if (alu_done) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_stop || stop) m_running = 0;
                    else if (m_pc == int'(last_addr) && !loop_en) begin
                        m_running = 0; m_done = 1;
                    end else begin
                        m_pc = (m_pc == int'(last_addr)) ? 0 : (m_pc + 1) % DEP;
                        m_issue_next = 1;
                    end
                end else begin
                    if (stop) m_stop = 1;
                    m_waited++;
                    if (m_waited == TO) begin m_err = 1; m_running = 0; end
                end
            end
        end
    end

    // Compare and monitor process.
    logic            chk_on = 0, prev_err = 0;
    int              en_cnt = 0, done_cnt = 0, en_cyc = 0, err_cyc = 0;
    int              en_pcs[$];
    logic [IW-1:0]   en_words[$];

    always @(negedge clk) begin
        if (chk_on)
            chk("cycle", {20'd0, a, b, op, acc, alu_en, busy, done, err, pc, op_count},
                {20'd0, m_a, m_b, m_op, m_acc, m_alu_en, m_running, m_done, m_err, AW'(m_pc), 16'(m_cnt)});
        if (alu_en) begin
            en_cnt++;
            en_pcs.push_back(int'(pc));
            en_words.push_back({acc, b, a, op});
            en_cyc = cyc;
        end
        if (done) done_cnt++;
        if (err && !prev_err) err_cyc = cyc;
        prev_err = err;
    end

    // ALU stand-in: completes two cycles after each issue pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_on && alu_en) begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                resp_done = 1'b1;
                @(posedge clk); #1;
                resp_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        en_cnt = 0; done_cnt = 0;
        en_pcs.delete();
        en_words.delete();
    endtask

    task automatic load(input logic [AW-1:0] ad, input logic [IW-1:0] w);
        prog_we = 1'b1; prog_addr = ad; prog_wdata = w;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n = 0;
        while (busy && n < max) begin tick(); n++; end
        chk(nm, 64'(busy), 64'd0);
        tick(); tick();
    endtask

    task automatic wait_en(input string nm, input int target, input int max);
        int n = 0;
        while (en_cnt < target && n < max) begin tick(); n++; end
        chk(nm, 64'(en_cnt >= target), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
        $fatal(1);
    end

    logic [IW-1:0] w0, w1, w2, w3, wx, wy;
    int exp_order1[4] = '{0, 1, 2, 3};
    int exp_order2[5] = '{0, 1, 0, 1, 0};

    initial begin
        w0 = mkw(0, 8'h11, 8'h22, 1);
        w1 = mkw(1, 8'h33, 8'h44, 2);
        w2 = mkw(0, 8'hA5, 8'h5A, 15);
        w3 = mkw(1, 8'hFF, 8'h00, 7);
        wx = mkw(1, 8'hEE, 8'hDD, 9);
        wy = mkw(0, 8'h12, 8'h34, 3);

        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_outputs", {20'd0, a, b, op, acc, alu_en, busy, done, err, pc, op_count}, 64'd0);

        // Four-word program, single pass; stray stop in idle and start mid-run ignored.
        load(0, w0); load(1, w1); load(2, w2); load(3, w3);
        stop = 1'b1; tick(); stop = 1'b0;
        resp_on = 1'b1; loop_en = 1'b0; last_addr = 3'd3;
        clear_mon();
        pulse_start();
        tick(); tick();
        pulse_start();
        wait_idle("run1_finish", 100);
        chk("run1_issues", 64'(en_cnt), 64'd4);
        chk("run1_done_pulses", 64'(done_cnt), 64'd1);
        chk("run1_op_count", 64'(op_count), 64'd4);
        for (int i = 0; i < 4; i++) chk("run1_order", 64'(en_pcs[i]), 64'(exp_order1[i]));
        chk("run1_word0", 64'(en_words[0]), 64'(w0));
        chk("run1_word1", 64'(en_words[1]), 64'(w1));
        chk("run1_word2_lit", 64'(en_words[2]), 64'h0A55AF);
        chk("run1_word3", 64'(en_words[3]), 64'(w3));

        // Looping two-word program, stop during the fifth op.
        loop_en = 1'b1; last_addr = 3'd1;
        clear_mon();
        pulse_start();
        wait_en("loop_reach5", 5, 100);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle("loop_finish", 50);
        for (int i = 0; i < 5; i++) chk("loop_order", 64'(en_pcs[i]), 64'(exp_order2[i]));
        chk("loop_issues", 64'(en_cnt), 64'd5);
        chk("loop_no_done", 64'(done_cnt), 64'd0);
        chk("loop_op_count", 64'(op_count), 64'd5);

        // Start+stop together: start wins; write while busy is dropped.
        loop_en = 1'b0; last_addr = 3'd1;
        clear_mon();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        tick();
        load(0, wx);
        wait_idle("busywr_finish", 50);
        chk("startstop_done", 64'(done_cnt), 64'd1);
        chk("startstop_issues", 64'(en_cnt), 64'd2);
        last_addr = 3'd0;
        clear_mon();
        pulse_start();
        wait_idle("readback_finish", 50);
        chk("busywr_readback", 64'(en_words[0]), 64'(w0));

        // Write and start on the same edge: the new word executes.
        clear_mon();
        prog_we = 1'b1; prog_addr = 3'd0; prog_wdata = wy; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_idle("wrstart_finish", 50);
        chk("wrstart_word", 64'(en_words[0]), 64'(wy));
        chk("wrstart_done", 64'(done_cnt), 64'd1);

        // Timeout with the ALU silent.
        resp_on = 1'b0;
        clear_mon();
        pulse_start();
        wait_idle("timeout_finish", 50);
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_latency", 64'(err_cyc - en_cyc), 64'd4);
        chk("timeout_pc", 64'(pc), 64'd0);
        chk("timeout_no_done", 64'(done_cnt), 64'd0);
        chk("timeout_op_count", 64'(op_count), 64'd0);

        // Reset in the middle of a wait; a late alu_done must do nothing.
        last_addr = 3'd3;
        clear_mon();
        pulse_start();
        wait_en("rstwait_issue", 1, 20);
        rst = 1'b1;
        #1;
        chk("rstwait_outputs", {20'd0, a, b, op, acc, alu_en, busy, done, err, pc, op_count}, 64'd0);
        tick();
        rst = 1'b0;
        man_done = 1'b1;
        tick(); tick();
        man_done = 1'b0;
        tick();
        chk("rstwait_pc", 64'(pc), 64'd0);
        chk("rstwait_busy", 64'(busy), 64'd0);
        chk("rstwait_no_issue", 64'(en_cnt), 64'd1);
        chk("rstwait_no_done", 64'(done_cnt), 64'd0);

        // Wide build: field decode of a 16-bit / 5-bit-opcode word.
        p16_we = 1'b1; p16_addr = 2'd0;
        p16_wdata = {1'b1, 16'h1234, 16'hBEEF, 5'h1F};
        tick();
        p16_we = 1'b0;
        start16 = 1'b1; tick(); start16 = 1'b0;
        tick();
        chk("w16_alu_en", 64'(alu_en16), 64'd1);
        chk("w16_a", 64'(a16), 64'hBEEF);
        chk("w16_b", 64'(b16), 64'h1234);
        chk("w16_op", 64'(op16), 64'h1F);
        chk("w16_acc", 64'(acc16), 64'd1);
        chk("w16_status", {59'd0, busy16, done16, err16, pc16}, {59'd0, 1'b1, 1'b0, 1'b0, 2'd0});
        chk("w16_count", 64'(cnt16), 64'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, operand width.
REQ-002 Parameter OP_W, default 4, opcode width.
REQ-003 Parameter DEPTH, default 32, program words, power of two >= 2; AW = log2(DEPTH).
REQ-004 Parameter TIMEOUT, default 255, max WAIT cycles before error, >= 1.
REQ-005 Derived IW = 1 + 2*DATA_W + OP_W; word fields: [IW-1] acc, [IW-2:OP_W+DATA_W] b, [OP_W+DATA_W-1:OP_W] a, [OP_W-1:0] op.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 prog_we  in  1  program write strobe.
REQ-009 prog_addr  in  AW  program write address.
REQ-010 prog_wdata  in  IW  program write word.
REQ-011 start  in  1  begin execution at address 0.
REQ-012 stop  in  1  request graceful halt.
REQ-013 loop_en  in  1  wrap to 0 after last_addr instead of finishing.
REQ-014 last_addr  in  AW  final program address.
REQ-015 alu_done  in  1  ALU completion, level sampled.
REQ-016 a, b  out  DATA_W each  operands to ALU.
REQ-017 op  out  OP_W  opcode; acc  out  1  accumulator select.
REQ-018 alu_en  out  1  one-cycle issue pulse.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 done  out  1  one-cycle pulse on normal completion.
REQ-021 err  out  1  sticky timeout flag.
REQ-022 pc  out  AW  current address; op_count  out  16  completed ops since start, saturating.

Function
REQ-023 States IDLE, ISSUE, WAIT; encoding 2 bits.
REQ-024 IDLE: start high -> pc=0, op_count=0, err=0, stop_req=0, next ISSUE.
REQ-025 ISSUE: register a/b/op/acc from mem[pc], alu_en=1, timer=0, next WAIT; alu_en high exactly the cycle after ISSUE edge.
REQ-026 WAIT: alu_en=0; alu_done high -> op_count+1 (saturate 0xFFFF), then completion decision REQ-027; else timer+1.
REQ-027 Completion: stop_req or stop high -> IDLE, no done pulse; else pc==last_addr and loop_en=0 -> IDLE, done=1; pc==last_addr and loop_en=1 -> pc=0, ISSUE; else pc+1, ISSUE.
REQ-028 WAIT timer reaching TIMEOUT with alu_done low -> err=1, IDLE, no done, pc holds faulting address.
REQ-029 alu_done in IDLE or ISSUE ignored; alu_done and timeout same edge -> alu_done wins.
REQ-030 stop high in ISSUE/WAIT sets stop_req; op in flight completes first; stop in IDLE ignored.
REQ-031 start while busy ignored; start and stop both high in IDLE -> start taken, stop ignored.
REQ-032 prog_we honoured only in IDLE; ignored while busy; write and start same edge -> write lands, execution sees new word.
REQ-033 pc wraps modulo DEPTH; last_addr >= DEPTH impossible by width.
REQ-034 a/b/op/acc hold last issued values until next ISSUE.

Reset
REQ-035 rst -> state IDLE, pc=0, a=b=op=acc=0, alu_en=0, done=0, err=0, op_count=0, stop_req=0, timer=0; program memory not cleared.
REQ-036 rst mid-WAIT aborts immediately, no done pulse; alu_done after release ignored until next ISSUE.

Structure
REQ-037 Package alu_seq_pkg holds state enum and field offset functions of DATA_W/OP_W.
REQ-038 Sub-module seq_prog_mem: DEPTH x IW, one sync write port, one async read port.

Verification
REQ-039 Load 4 words, last_addr=3, start, ALU answers done 2 cycles after each alu_en -> 4 alu_en pulses, op/a/b match words, done once, op_count=4.
REQ-040 loop_en=1, last_addr=1, stop asserted during 5th op -> issue order 0,1,0,1,0, IDLE after 5th done, no done pulse.
REQ-041 TIMEOUT=4, alu_done never -> err=1 exactly 4 WAIT cycles after alu_en, busy=0, pc=0.
REQ-042 prog_we while busy with new word -> memory unchanged on readback in next run.
REQ-043 rst asserted in WAIT -> all outputs zero immediately, later alu_done produces no pc change.
REQ-044 DATA_W=16, OP_W=5 build: word a=0xBEEF, b=0x1234, op=0x1F, acc=1 decoded exactly.
